// File: rtl/cnt_step_checker.sv
// cnt_step_checker: watches an 8-bit up/down counter and checks that every
// sample is exactly one step (mod 256) from the previous one.
// It counts wrap-arounds and step errors, and enters a sticky FAULT state
// after a run of consecutive errors.
// Each error is logged as an {expected, actual} record in a small FIFO.

package cnt_step_checker_pkg;

  // One error record as seen by the debug/CSR consumer.
  typedef struct packed {
    logic [7:0] exp_val;
    logic [7:0] act_val;
  } evt_rec_t;

endpackage

module cnt_step_checker
  import cnt_step_checker_pkg::*;
#(
  parameter bit          DIR       = 1'b1,
  parameter int unsigned FAULT_THR = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       cnt_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic             wrap_o,
  output logic             err_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] wrap_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             ovf_o,
  output logic             evt_valid_o,
  output logic [15:0]      evt_data_o,
  input  logic             evt_ready_i
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = AW + 1;
  localparam int unsigned CON_W = 4;
  // Value reached by a legal wrap: FF->00 counting up, 00->FF counting down.
  localparam logic [7:0]  WRAP_VAL = DIR ? 8'h00 : 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       prev;
  logic [CON_W-1:0] consec;

  logic [7:0]       exp_c;
  logic             match_c;
  logic             check_c;
  logic             wrap_hit_c;
  logic             push_c;
  logic [CON_W-1:0] consec_inc_c;
  logic             thr_hit_c;
  evt_rec_t         push_rec_c;
  logic             pop_c;
  logic             full_c;
  logic             push_acc_c;
  logic             drop_c;
  logic [OCC_W-1:0] occ_nxt_c;
  evt_rec_t         head_nxt_c;

  evt_rec_t         mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OCC_W-1:0] occ;
  evt_rec_t         head;

  // Step check, push/pop qualification and FIFO next-state decode.
  always_comb begin
    exp_c        = DIR ? (prev + 8'd1) : (prev - 8'd1);
    match_c      = (cnt_i == exp_c);
    check_c      = !clr_i && en_i && (state == ST_TRACK);
    wrap_hit_c   = match_c && (cnt_i == WRAP_VAL);
    push_c       = check_c && !match_c;
    consec_inc_c = consec + CON_W'(1);
    thr_hit_c    = (consec_inc_c == CON_W'(FAULT_THR));
    push_rec_c.exp_val = exp_c;
    push_rec_c.act_val = cnt_i;

    // A clear discards any handshake that lands on the same edge.
    pop_c      = !clr_i && evt_valid_o && evt_ready_i;
    full_c     = (occ == OCC_W'(DEPTH));
    push_acc_c = push_c && (!full_c || pop_c);
    drop_c     = push_c && full_c && !pop_c;

    occ_nxt_c = occ;
    if (push_acc_c && !pop_c) begin
      occ_nxt_c = occ + OCC_W'(1);
    end else if (!push_acc_c && pop_c) begin
      occ_nxt_c = occ - OCC_W'(1);
    end

    // Head register tracks the oldest record so evt_data_o is a flop output.
    head_nxt_c = head;
    if (occ_nxt_c == '0) begin
      head_nxt_c = '0;
    end else if (pop_c) begin
      head_nxt_c = (occ == OCC_W'(1)) ? push_rec_c : mem[rd_ptr + AW'(1)];
    end else if (occ == '0) begin
      head_nxt_c = push_rec_c;
    end
  end

  // Checker FSM with its registered pulses, fault flag and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      prev       <= 8'h00;
      consec     <= '0;
      wrap_o     <= 1'b0;
      err_o      <= 1'b0;
      fault_o    <= 1'b0;
      wrap_cnt_o <= '0;
      err_cnt_o  <= '0;
    end else if (clr_i) begin
      state      <= ST_IDLE;
      consec     <= '0;
      wrap_o     <= 1'b0;
      err_o      <= 1'b0;
      fault_o    <= 1'b0;
      wrap_cnt_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      wrap_o <= 1'b0;
      err_o  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // First enabled sample only seeds the reference value.
          if (en_i) begin
            prev  <= cnt_i;
            state <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (!en_i) begin
            state  <= ST_IDLE;
            consec <= '0;
          end else begin
            // Resynchronise on the actual value whether or not it matched.
            prev <= cnt_i;
            if (match_c) begin
              consec <= '0;
              if (wrap_hit_c) begin
                wrap_o <= 1'b1;
                if (wrap_cnt_o != '1) begin
                  wrap_cnt_o <= wrap_cnt_o + CNT_W'(1);
                end
              end
            end else begin
              err_o  <= 1'b1;
              consec <= consec_inc_c;
              if (err_cnt_o != '1) begin
                err_cnt_o <= err_cnt_o + CNT_W'(1);
              end
              if (thr_hit_c) begin
                state   <= ST_FAULT;
                fault_o <= 1'b1;
              end
            end
          end
        end
        ST_FAULT: begin
          // Sticky until the checker is disabled or cleared.
          if (!en_i) begin
            state   <= ST_IDLE;
            consec  <= '0;
            fault_o <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          consec  <= '0;
          fault_o <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_acc_c) begin
      mem[wr_ptr] <= push_rec_c;
    end
  end

  // FIFO pointers, occupancy, registered head/valid and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      evt_valid_o <= 1'b0;
      head        <= '0;
      ovf_o       <= 1'b0;
    end else if (clr_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      evt_valid_o <= 1'b0;
      head        <= '0;
      ovf_o       <= 1'b0;
    end else begin
      if (push_acc_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (drop_c) begin
        ovf_o <= 1'b1;
      end
      occ         <= occ_nxt_c;
      evt_valid_o <= (occ_nxt_c != '0);
      head        <= head_nxt_c;
    end
  end

  assign evt_data_o = head;

endmodule
